// File: rtl/fsm1_run_encoder.sv
// Run-length encoder for the fsm1 dout stream: folds equal consecutive samples
// into {level, length} records and buffers them in a small FIFO for the trace stage.
module fsm1_run_encoder #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             flush,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_level,
  output logic [CNT_W-1:0] rec_len,
  output logic             overflow,
  output logic             dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] MAX_LEN  = {CNT_W{1'b1}};
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

  logic             state_q, state_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             push;
  logic [CNT_W:0]   push_rec;

  logic [CNT_W:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop, full, wr_en, drop;
  logic [CNT_W:0]   head;

  // Encoder: flush outranks the sample compare, so at most one record per cycle.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    len_d    = len_q;
    push     = 1'b0;
    push_rec = {level_q, len_q};
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          state_d = ST_RUN;
          level_d = din;
          len_d   = CNT_W'(1);
        end
      end
      default: begin
        if (flush) begin
          push = 1'b1;
          if (din_valid) begin
            level_d = din;
            len_d   = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (din_valid) begin
          if (din != level_q) begin
            push    = 1'b1;
            level_d = din;
            len_d   = CNT_W'(1);
          end else if (len_q == MAX_LEN) begin
            push  = 1'b1;
            len_d = CNT_W'(1);
          end else begin
            len_d = len_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Handshake: a record transfers on any rising edge where rec_valid && rec_ready;
  // while rec_valid is high and rec_ready low the head record is held unchanged.
  assign pop   = rec_valid && rec_ready;
  assign full  = (count_q == FULL_CNT);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    if (wr_en && !pop) count_d = count_q + (AW+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      level_q    <= 1'b0;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count_q covers it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_rec;
  end

  assign head        = mem_q[rd_ptr_q];
  assign rec_valid   = (count_q != '0);
  assign rec_level   = rec_valid & head[CNT_W];
  assign rec_len     = rec_valid ? head[CNT_W-1:0] : '0;
  assign overflow    = overflow_q;
  // High while a run is open, low in IDLE.
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fsm1_run_encoder.sv
// Bench for fsm1_run_encoder: directed scenarios plus random traffic, all
// checked cycle by cycle against a run-list / record-queue reference model.
module tb_fsm1_run_encoder;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int MAXL  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             areset_n = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             flush = 1'b0;
  logic             rec_ready = 1'b0;
  logic             rec_valid;
  logic             rec_level;
  logic [CNT_W-1:0] rec_len;
  logic             overflow;
  logic             dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the open run and the records awaiting delivery.
  logic [CNT_W:0] exp_q[$];
  bit             run_open;
  bit             run_level;
  int             run_len;
  bit             exp_ovf;

  logic rv, rd, rf, rr, cur_d;

  fsm1_run_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset_n(areset_n), .din_valid(din_valid), .din(din),
    .flush(flush), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_level(rec_level), .rec_len(rec_len), .overflow(overflow),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    run_open  = 1'b0;
    run_level = 1'b0;
    run_len   = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic f, input logic r);
    bit             have;
    logic [CNT_W:0] rec;
    bit             do_pop;
    have = 1'b0;
    rec  = '0;
    if (run_open && f) begin
      have = 1'b1;
      rec  = {run_level, CNT_W'(run_len)};
      if (v) begin run_level = d; run_len = 1; end
      else run_open = 1'b0;
    end else if (run_open && v) begin
      if (d != run_level || run_len == MAXL) begin
        have = 1'b1;
        rec  = {run_level, CNT_W'(run_len)};
        run_level = d;
        run_len   = 1;
      end else begin
        run_len++;
      end
    end else if (v) begin
      run_open  = 1'b1;
      run_level = d;
      run_len   = 1;
    end
    do_pop = (exp_q.size() != 0) && r;
    if (do_pop) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(rec);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    bit ev;
    ev = (exp_q.size() != 0);
    check_eq("rec_valid", 32'(rec_valid), 32'(ev));
    check_eq("rec_level", 32'(rec_level), ev ? 32'(exp_q[0][CNT_W]) : 32'd0);
    check_eq("rec_len",   32'(rec_len),   ev ? 32'(exp_q[0][CNT_W-1:0]) : 32'd0);
    check_eq("overflow",  32'(overflow),  32'(exp_ovf));
    check_eq("run_open",  32'(dbg_state_o), 32'(run_open));
  endtask

  task automatic step(input logic v, input logic d, input logic f, input logic r);
    din_valid = v;
    din       = d;
    flush     = f;
    rec_ready = r;
    model_step(v, d, f, r);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    areset_n  = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    flush     = 1'b0;
    rec_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    compare_outputs();
  endtask

  initial begin
    model_reset();

    // Basic: 1,1,1,0,0 then flush, drained afterwards.
    do_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 1);

    // Saturating run: 257 ones, a zero, flush.
    do_reset();
    repeat (257) step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 1);

    // Overflow: six alternating samples with the consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1'(i & 1), 0, 0);
    repeat (6) step(0, 0, 0, 1);

    // Full FIFO with a simultaneous pop: no drop.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1'(i & 1), 0, 0);
    step(1, 1'b1, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);

    // Gaps inside a run of zeros do not split it.
    do_reset();
    step(1, 0, 0, 1); step(0, 1, 0, 1); step(1, 0, 0, 1);
    step(0, 1, 0, 1); step(0, 1, 0, 1); step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    repeat (3) step(0, 0, 0, 1);

    // Asynchronous reset mid-cycle with a run open and two records buffered.
    do_reset();
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    #3;
    areset_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Random traffic with sticky runs, occasional flushes and stalls.
    do_reset();
    cur_d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) cur_d = ~cur_d;
      rd = cur_d;
      rf = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 9) < 6);
      step(rv, rd, rf, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm1_run_encoder.md
# fsm1_run_encoder

Run-length encoder sitting directly downstream of the fsm1 Moore state machine, consuming its 1-bit `dout` stream. It compresses consecutive equal samples into `{level, length}` records and buffers them in a small FIFO. Records are delivered over a valid/ready handshake to the trace/logging stage.

## Interface
Parameters:
- `CNT_W`, 8, width of run-length field; MAX = 2^CNT_W − 1
- `DEPTH`, 4, FIFO depth in records (power of two, ≥ 2)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `areset_n`  in  1  asynchronous, active-low reset
- `din_valid`  in  1  sample qualifier; `din` accepted on a rising edge only when high
- `din`  in  1  fsm1 `dout` sample
- `flush`  in  1  close the open run and emit it
- `rec_valid`  out  1  FIFO head valid
- `rec_ready`  in  1  consumer accepts head when `rec_valid && rec_ready`
- `rec_level`  out  1  level of head record
- `rec_len`  out  CNT_W  length of head record, range 1..MAX
- `overflow`  out  1  sticky: a record was dropped

## Operation
- Clock `clk`; reset is asynchronous and active-low on `areset_n`.
- Encoder states:
  - IDLE: no open run.
  - RUN: open run with registers `cur_level` and `cur_len`.
- In IDLE:
  - Accepted sample → RUN, `cur_level=din`, `cur_len=1`, no push.
  - `flush` alone → no effect.
- In RUN, for an accepted sample:
  - `din != cur_level`: push `{cur_level, cur_len}`; then `cur_level=din`, `cur_len=1`.
  - `din == cur_level` and `cur_len < MAX`: `cur_len++`, no push.
  - `din == cur_level` and `cur_len == MAX`: push `{cur_level, MAX}`; `cur_len=1`; stay in RUN.
- `flush` in RUN:
  - Push `{cur_level, cur_len}`.
  - No accepted sample in the same cycle → IDLE.
  - Accepted sample in the same cycle → RUN with `cur_level=din`, `cur_len=1`.
  - `flush` has priority over the sample's compare, so at most one push per cycle.
- `din_valid=0` cycles: run state frozen; gaps do not split runs.
- FIFO:
  - Head appears on `rec_level`/`rec_len`; both read 0 when `rec_valid=0`.
  - Pop on `rec_valid && rec_ready`.
- Push when full:
  - With a pop in the same cycle: push accepted, occupancy unchanged.
  - With no pop: record dropped, FIFO contents unchanged, `overflow` ← 1.
- `overflow` clears only on reset.
- Simultaneous push and pop on an empty FIFO: the push is stored; no bypass.

## Timing
- Reset values: IDLE, FIFO empty, `rec_valid=0`, `rec_level=0`, `rec_len=0`, `overflow=0`.
- Reset mid-operation discards the open run and all buffered records immediately, without waiting for a clock edge.
- Latency: if the terminating sample or `flush` is accepted at edge t, the record is pushed at t. With an empty FIFO, `rec_valid` rises after edge t, so it is visible in cycle t+1.
- `rec_valid` and the head fields stay stable until popped; they never change while `rec_valid && !rec_ready`.
- Throughput: one push and one pop per cycle. Back-to-back pops drain one record per cycle.
- `overflow` rises after the edge at which the drop occurs.

## Test plan
- Reset, then samples 1,1,1,0,0, `flush` → records {1,3} and {0,2}. `rec_valid` first high the cycle after the first 0 is accepted.
- 257 consecutive 1s with `CNT_W=8`, then a 0, then `flush` → records {1,255}, {1,2}, {0,1}.
- `rec_ready=0`, alternating din for 6 samples, `DEPTH=4`:
  - 5 records attempted → FIFO holds the first 4, `overflow=1`.
  - Then `rec_ready=1` → exactly 4 records drain with correct order and values.
- FIFO full with `rec_ready=1` during a push → no drop, `overflow` stays 0, occupancy stays 4.
- `din_valid` gaps inside a run of 0s (pattern 0,gap,0,gap,gap,0), then a 1 → single record {0,3}.
- Run open at `cur_len=5` with 2 records buffered, assert `areset_n=0` mid-cycle → outputs go to reset values before the next edge. After release, `flush` alone produces no record.
